// File: rtl/cv32e40p_scnn_ctrl_if.sv
// Operand-beat and result-drain handshake bundle for the SCNN controller.
// The slave side is the controller; the master side feeds beats and drains rows.
interface cv32e40p_scnn_ctrl_if;
   logic                     op_valid_i;
   logic                     op_ready_o;
   logic signed [3:0][7:0]   filter_i;
   logic        [3:0][7:0]   input_i;
   logic                     res_valid_o;
   logic                     res_ready_i;
   logic signed [15:0][15:0] res_row_o;
   logic        [2:0]        res_idx_o;

   modport slave (
      input  op_valid_i,
      input  filter_i,
      input  input_i,
      input  res_ready_i,
      output op_ready_o,
      output res_valid_o,
      output res_row_o,
      output res_idx_o
   );

   modport master (
      output op_valid_i,
      output filter_i,
      output input_i,
      output res_ready_i,
      input  op_ready_o,
      input  res_valid_o,
      input  res_row_o,
      input  res_idx_o
   );
endinterface

// File: rtl/cv32e40p_scnn_ctrl.sv
// SCNN job controller: accepts operand beats, holds 8x16 accumulators, drains rows.
// CV32E40P_SCNN_CTRL_PERF_EN enables the perf_stall_o stall counter.
module cv32e40p_scnn_ctrl #(
   parameter int unsigned BEAT_CNT_W = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start_i,
   input  logic [BEAT_CNT_W-1:0]         num_beats_i,
   output logic                          busy_o,
   output logic                          done_o,
   output logic        [3:0][7:0]        mul_filter_o,
   output logic        [3:0][7:0]        mul_input_o,
   output logic signed [7:0][15:0][15:0] mul_cache_o,
   input  logic signed [7:0][15:0][15:0] mul_cache_i,
   output logic [31:0]                   perf_stall_o,
   cv32e40p_scnn_ctrl_if.slave           bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_e;

   localparam logic [BEAT_CNT_W-1:0] ONE = BEAT_CNT_W'(1);

   state_e                       state_q, state_d;
   logic signed [7:0][15:0][15:0] acc_q, acc_d;
   logic [BEAT_CNT_W-1:0]        beats_q, beats_d;
   logic [BEAT_CNT_W-1:0]        cnt_q, cnt_d;
   logic [2:0]                   idx_q, idx_d;
   logic                         done_q, done_d;

   logic is_idle, is_run, is_drain;
   logic op_hs, res_hs, last_beat;

   assign is_idle   = (state_q == IDLE);
   assign is_run    = (state_q == RUN);
   assign is_drain  = (state_q == DRAIN);
   assign op_hs     = is_run & bus.op_valid_i;
   assign res_hs    = is_drain & bus.res_ready_i;
   assign last_beat = (cnt_q + ONE) == beats_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (1'b1)
         is_idle: begin
            if (start_i) begin
               state_d = (num_beats_i == '0) ? DRAIN : RUN;
            end
         end
         is_run: begin
            if (op_hs && last_beat) state_d = DRAIN;
         end
         is_drain: begin
            if (res_hs && idx_q == 3'd7) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy_o           = ~is_idle;
      done_o           = done_q;
      bus.op_ready_o   = is_run;
      bus.res_valid_o  = is_drain;
      bus.res_idx_o    = is_drain ? idx_q : 3'd0;
      bus.res_row_o    = acc_q[idx_q];
      mul_filter_o     = bus.filter_i;
      mul_input_o      = bus.input_i;
      mul_cache_o      = acc_q;
   end

   always_comb begin
      acc_d   = acc_q;
      beats_d = beats_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      done_d  = 1'b0;
      unique case (1'b1)
         is_idle: begin
            if (start_i) begin
               beats_d = num_beats_i;
               cnt_d   = '0;
               acc_d   = '0;
               idx_d   = 3'd0;
            end
         end
         is_run: begin
            if (op_hs) begin
               acc_d = mul_cache_i;
               cnt_d = cnt_q + ONE;
               idx_d = 3'd0;
            end
         end
         is_drain: begin
            // Row index wraps 7 -> 0, leaving it cleared for the next job
            if (res_hs) begin
               idx_d  = idx_q + 3'd1;
               done_d = (idx_q == 3'd7);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q   <= '0;
         beats_q <= '0;
         cnt_q   <= '0;
         idx_q   <= 3'd0;
         done_q  <= 1'b0;
      end else begin
         acc_q   <= acc_d;
         beats_q <= beats_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         done_q  <= done_d;
      end
   end

`ifdef CV32E40P_SCNN_CTRL_PERF_EN
   logic [31:0] stall_q, stall_d;
   logic        stall_hit;

   assign stall_hit = (is_run & ~bus.op_valid_i) |
                      (is_drain & ~bus.res_ready_i);

   always_comb begin
      stall_d = stall_q;
      if (stall_hit) stall_d = stall_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end

   assign perf_stall_o = stall_q;
`else
   assign perf_stall_o = 32'd0;
`endif

endmodule

// File: tb/tb_cv32e40p_scnn_ctrl.sv
// Directed bench for cv32e40p_scnn_ctrl with a behavioural spike-multiply datapath.
// Accumulator column = filter*4 + input lane; row = timestep bit of the input lane.
module tb_cv32e40p_scnn_ctrl;

   logic                          clk = 1'b0;
   logic                          rst;
   logic                          start_i;
   logic [7:0]                    num_beats_i;
   logic                          busy_o;
   logic                          done_o;
   logic        [3:0][7:0]        mul_filter_o;
   logic        [3:0][7:0]        mul_input_o;
   logic signed [7:0][15:0][15:0] mul_cache_o;
   logic signed [7:0][15:0][15:0] mul_cache_i;
   logic [31:0]                   perf_stall_o;

   cv32e40p_scnn_ctrl_if bus ();

   cv32e40p_scnn_ctrl #(.BEAT_CNT_W(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .start_i      (start_i),
      .num_beats_i  (num_beats_i),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .mul_filter_o (mul_filter_o),
      .mul_input_o  (mul_input_o),
      .mul_cache_o  (mul_cache_o),
      .mul_cache_i  (mul_cache_i),
      .perf_stall_o (perf_stall_o),
      .bus          (bus.slave)
   );

   always #5 clk = ~clk;

`ifdef CV32E40P_SCNN_CTRL_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   always_comb begin
      mul_cache_i = mul_cache_o;
      for (int t = 0; t < 8; t++) begin
         for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < 4; i++) begin
               if (mul_input_o[i][t]) begin
                  mul_cache_i[t][f*4+i] = mul_cache_i[t][f*4+i] +
                                          16'($signed(mul_filter_o[f]));
               end
            end
         end
      end
   end

   int n_vec = 0;
   int n_err = 0;
   int done_cnt = 0;
   bit rdy_seen = 1'b0;
   logic signed [7:0][15:0][15:0] rows;
   logic [15:0][15:0] exp_row;

   always @(negedge clk) begin
      if (done_o) done_cnt++;
      if (bus.op_ready_o) rdy_seen = 1'b1;
   end

   task automatic chk(input string tag, input logic [255:0] act,
                      input logic [255:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic do_start(input logic [7:0] n);
      start_i     = 1'b1;
      num_beats_i = n;
      step();
      start_i     = 1'b0;
   endtask

   task automatic beat();
      bus.op_valid_i = 1'b1;
      step();
      bus.op_valid_i = 1'b0;
   endtask

   task automatic drain(input string tag);
      bus.res_ready_i = 1'b1;
      for (int r = 0; r < 8; r++) begin
         chk({tag, "_vld"}, 256'(bus.res_valid_o), 256'(1));
         chk({tag, "_idx"}, 256'(bus.res_idx_o), 256'(r));
         rows[r] = bus.res_row_o;
         step();
      end
      bus.res_ready_i = 1'b0;
      chk({tag, "_done"}, 256'(done_o), 256'(1));
      chk({tag, "_busy"}, 256'(busy_o), 256'(0));
   endtask

   function automatic int nz(input logic [7:0][15:0][15:0] a);
      int c = 0;
      for (int t = 0; t < 8; t++)
         for (int k = 0; k < 16; k++)
            if (a[t][k] != 16'h0) c++;
      return c;
   endfunction

   task automatic set_beat(input logic [7:0] in0);
      bus.filter_i    = '0;
      bus.filter_i[0] = 8'sd3;
      bus.filter_i[1] = -8'sd2;
      bus.input_i     = '0;
      bus.input_i[0]  = in0;
   endtask

   initial begin
      int d0;
      rst             = 1'b0;
      start_i         = 1'b0;
      num_beats_i     = '0;
      bus.op_valid_i  = 1'b0;
      bus.res_ready_i = 1'b0;
      set_beat(8'h01);
      do_reset();

      chk("rst_busy",  256'(busy_o),          256'(0));
      chk("rst_done",  256'(done_o),          256'(0));
      chk("rst_rdy",   256'(bus.op_ready_o),  256'(0));
      chk("rst_vld",   256'(bus.res_valid_o), 256'(0));
      chk("rst_idx",   256'(bus.res_idx_o),   256'(0));
      chk("rst_perf",  256'(perf_stall_o),    256'(0));
      chk("rst_acc",   256'(nz(mul_cache_o)), 256'(0));

      // single beat
      d0 = done_cnt;
      do_start(8'd1);
      chk("t1_rdy", 256'(bus.op_ready_o), 256'(1));
      chk("t1_busy", 256'(busy_o), 256'(1));
      beat();
      chk("t1_vld_lat", 256'(bus.res_valid_o), 256'(1));
      chk("t1_rdy_drn", 256'(bus.op_ready_o), 256'(0));
      drain("t1");
      chk("t1_c0", 256'(rows[0][0]), 256'(16'h0003));
      chk("t1_c4", 256'(rows[0][4]), 256'(16'hFFFE));
      chk("t1_nz", 256'(nz(rows)), 256'(2));
      step();
      chk("t1_done_off", 256'(done_o), 256'(0));
      chk("t1_done_cnt", 256'(done_cnt - d0), 256'(1));
      chk("t1_retain", 256'(mul_cache_o[0][0]), 256'(16'h0003));
      chk("t1_idx_idle", 256'(bus.res_idx_o), 256'(0));

      // gapped beats
      do_reset();
      do_start(8'd3);
      beat();
      step(); step();
      beat();
      step(); step();
      beat();
      drain("t2");
      chk("t2_c0", 256'(rows[0][0]), 256'(16'h0009));
      chk("t2_c4", 256'(rows[0][4]), 256'(16'hFFFA));
      chk("t2_perf", 256'(perf_stall_o), 256'(PERF ? 4 : 0));
      step();

      // zero job
      d0 = done_cnt;
      rdy_seen = 1'b0;
      do_start(8'd0);
      chk("t3_busy", 256'(busy_o), 256'(1));
      chk("t3_vld", 256'(bus.res_valid_o), 256'(1));
      drain("t3");
      chk("t3_nz", 256'(nz(rows)), 256'(0));
      step();
      chk("t3_rdy_seen", 256'(rdy_seen), 256'(0));
      chk("t3_done_cnt", 256'(done_cnt - d0), 256'(1));

      // backpressure at row 2
      do_reset();
      set_beat(8'h04);
      exp_row    = '0;
      exp_row[0] = 16'h0003;
      exp_row[4] = 16'hFFFE;
      do_start(8'd1);
      beat();
      bus.res_ready_i = 1'b1;
      step(); step();
      bus.res_ready_i = 1'b0;
      for (int k = 0; k < 5; k++) begin
         chk("t4_idx", 256'(bus.res_idx_o), 256'(2));
         chk("t4_row", 256'(bus.res_row_o), 256'(exp_row));
         step();
      end
      chk("t4_perf", 256'(perf_stall_o), 256'(PERF ? 5 : 0));
      bus.res_ready_i = 1'b1;
      for (int k = 2; k < 8; k++) begin
         chk("t4_tail_idx", 256'(bus.res_idx_o), 256'(k));
         step();
      end
      bus.res_ready_i = 1'b0;
      chk("t4_done", 256'(done_o), 256'(1));
      step();

      // reset mid-RUN
      set_beat(8'h01);
      do_start(8'd4);
      beat();
      beat();
      chk("t5_mid_run", 256'(bus.op_ready_o), 256'(1));
      do_reset();
      chk("t5_busy", 256'(busy_o), 256'(0));
      chk("t5_rdy", 256'(bus.op_ready_o), 256'(0));
      chk("t5_acc", 256'(nz(mul_cache_o)), 256'(0));
      do_start(8'd1);
      beat();
      drain("t5");
      chk("t5_c0", 256'(rows[0][0]), 256'(16'h0003));
      step();

      // start in DRAIN ignored; start in done cycle accepted
      do_start(8'd1);
      beat();
      start_i     = 1'b1;
      num_beats_i = 8'd5;
      step();
      start_i     = 1'b0;
      chk("t6_still_drn", 256'(bus.res_valid_o), 256'(1));
      chk("t6_idx", 256'(bus.res_idx_o), 256'(0));
      drain("t6");
      chk("t6_c0", 256'(rows[0][0]), 256'(16'h0003));
      chk("t6_c4", 256'(rows[0][4]), 256'(16'hFFFE));
      do_start(8'd1);
      chk("t6_restart", 256'(bus.op_ready_o), 256'(1));
      chk("t6_clear", 256'(nz(mul_cache_o)), 256'(0));
      beat();
      drain("t6b");
      chk("t6b_c0", 256'(rows[0][0]), 256'(16'h0003));
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
